// File: rtl/nd_1to2_pkg.sv
// Shared constants, operator codes, FSM encodings and the range-compare helper
// used by the nd_1to2 router node and its output queues.
package nd_1to2_pkg;

  localparam int NS_OFF   = 0;
  localparam int NS_ON    = 1;
  localparam int NS_FALSE = 0;
  localparam int NS_TRUE  = 1;

  localparam int NS_GT_OP  = 1;
  localparam int NS_GTE_OP = 2;
  localparam int NS_LT_OP  = 3;
  localparam int NS_LTE_OP = 4;
  localparam int NS_EQ_OP  = 5;
  localparam int NS_NEQ_OP = 6;

  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 4;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_DONE = 2'd2
  } out_state_t;

  typedef enum logic {
    IN_IDLE  = 1'b0,
    IN_ACKED = 1'b1
  } in_state_t;

  // Evaluates "v <op> rv" as an unsigned compare.
  function automatic logic ns_cmp_op(input int op, input logic [31:0] rv, input logic [31:0] v);
    case (op)
      NS_GT_OP:  ns_cmp_op = (v >  rv);
      NS_GTE_OP: ns_cmp_op = (v >= rv);
      NS_LT_OP:  ns_cmp_op = (v <  rv);
      NS_LTE_OP: ns_cmp_op = (v <= rv);
      NS_EQ_OP:  ns_cmp_op = (v == rv);
      NS_NEQ_OP: ns_cmp_op = (v != rv);
      default:   ns_cmp_op = 1'b0;
    endcase
  endfunction

  function automatic logic ns_range_cmp_op(input int is_range,
                                           input int op1, input logic [31:0] rv1, input logic [31:0] v1,
                                           input int op2, input logic [31:0] rv2, input logic [31:0] v2);
    logic c1;
    c1 = ns_cmp_op(op1, rv1, v1);
    if (is_range != NS_FALSE) ns_range_cmp_op = c1 && ns_cmp_op(op2, rv2, v2);
    else                      ns_range_cmp_op = c1;
  endfunction

endpackage

// File: rtl/nd_1to2_out_queue.sv
// nd_out_queue: QDEPTH-entry message FIFO feeding one 4-phase output channel.
// Optional delivery counter enabled by NS_ND_1TO2_STATS_EN.
module nd_out_queue
  import nd_1to2_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int ASZ    = NS_ADDRESS_SIZE,
  parameter int DSZ    = NS_DATA_SIZE
) (
  input  logic                   i_clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [2*ASZ+DSZ-1:0]   push_data,
  output logic                   full,
  output logic [ASZ-1:0]         o_src,
  output logic [ASZ-1:0]         o_dst,
  output logic [DSZ-1:0]         o_dat,
  output logic                   o_req,
  input  logic                   o_ack,
  output logic [15:0]            o_cnt
);

  localparam int AW = $clog2(QDEPTH);
  localparam int MW = 2*ASZ + DSZ;

  logic [MW-1:0] mem [QDEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, do_push, load, pop;
  out_state_t    state, state_nxt;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;

  always_ff @(posedge i_clk)
    if (do_push) mem[wptr[AW-1:0]] <= push_data;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      OUT_IDLE: if (!empty) begin state_nxt = OUT_REQ;  load = 1'b1; end
      OUT_REQ:  if (o_ack)  begin state_nxt = OUT_DONE; pop  = 1'b1; end
      OUT_DONE: if (!o_ack)       state_nxt = OUT_IDLE;
      default:                    state_nxt = OUT_IDLE;
    endcase
  end

  // The head stays in the queue until acked, so it still occupies a slot while presented.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state <= OUT_IDLE;
      wptr  <= '0;
      rptr  <= '0;
      o_req <= 1'b0;
      o_src <= '0;
      o_dst <= '0;
      o_dat <= '0;
    end else begin
      state <= state_nxt;
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (load) begin
        {o_src, o_dst, o_dat} <= mem[rptr[AW-1:0]];
        o_req <= 1'b1;
      end
      if (pop) o_req <= 1'b0;
    end
  end

`ifdef NS_ND_1TO2_STATS_EN
  logic [15:0] cnt;
  always_ff @(posedge i_clk or posedge reset)
    if (reset)    cnt <= '0;
    else if (pop) cnt <= cnt + 16'd1;
  assign o_cnt = cnt;
`else
  assign o_cnt = '0;
`endif

endmodule

// File: rtl/nd_1to2.sv
// nd_1to2: buffered 1-to-2 router; dst range compare picks output 0 (true) or 1.
// Delivery counters on o_cnt_0/o_cnt_1 exist only with NS_ND_1TO2_STATS_EN defined.
module nd_1to2
  import nd_1to2_pkg::*;
#(
  parameter int OPER_1    = NS_GT_OP,
  parameter int REF_VAL_1 = 0,
  parameter int IS_RANGE  = NS_FALSE,
  parameter int OPER_2    = NS_GT_OP,
  parameter int REF_VAL_2 = 0,
  parameter int QDEPTH    = 2,
  parameter int ASZ       = NS_ADDRESS_SIZE,
  parameter int DSZ       = NS_DATA_SIZE
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic           i0_req,
  output logic           i0_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic [ASZ-1:0] o1_src,
  output logic [ASZ-1:0] o1_dst,
  output logic [DSZ-1:0] o1_dat,
  output logic           o1_req,
  input  logic           o1_ack,
  output logic [15:0]    o_cnt_0,
  output logic [15:0]    o_cnt_1
);

  in_state_t            state, state_nxt;
  logic                 tgt0, tgt_full, full0, full1, push;
  logic [2*ASZ+DSZ-1:0] msg;

  assign msg      = {i0_src, i0_dst, i0_dat};
  assign tgt0     = ns_range_cmp_op(IS_RANGE, OPER_1, 32'(REF_VAL_1), 32'(i0_dst),
                                    OPER_2, 32'(REF_VAL_2), 32'(i0_dst));
  assign tgt_full = tgt0 ? full0 : full1;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IN_IDLE:  if (i0_req && !tgt_full) begin state_nxt = IN_ACKED; push = 1'b1; end
      IN_ACKED: if (!i0_req)                   state_nxt = IN_IDLE;
      default:                                 state_nxt = IN_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge reset)
    if (reset) state <= IN_IDLE;
    else       state <= state_nxt;

  // The state register doubles as the registered acknowledge.
  assign i0_ack = (state == IN_ACKED);

  nd_out_queue #(.QDEPTH(QDEPTH), .ASZ(ASZ), .DSZ(DSZ)) u_q0 (
    .i_clk(i_clk), .reset(reset), .push(push && tgt0), .push_data(msg), .full(full0),
    .o_src(o0_src), .o_dst(o0_dst), .o_dat(o0_dat), .o_req(o0_req), .o_ack(o0_ack),
    .o_cnt(o_cnt_0)
  );

  nd_out_queue #(.QDEPTH(QDEPTH), .ASZ(ASZ), .DSZ(DSZ)) u_q1 (
    .i_clk(i_clk), .reset(reset), .push(push && !tgt0), .push_data(msg), .full(full1),
    .o_src(o1_src), .o_dst(o1_dst), .o_dat(o1_dat), .o_req(o1_req), .o_ack(o1_ack),
    .o_cnt(o_cnt_1)
  );

endmodule

// File: tb/tb_nd_1to2.sv
// Directed bench for nd_1to2: default node plus a range-configured node (2 < dst < 5).
module tb_nd_1to2;
  import nd_1to2_pkg::*;

`ifdef NS_ND_1TO2_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       i_clk = 0;
  logic       reset = 1;
  logic [5:0] i0_src = 0, i0_dst = 0;
  logic [3:0] i0_dat = 0;
  logic       i0_req = 0, i0_ack;
  logic [5:0] o0_src, o0_dst, o1_src, o1_dst;
  logic [3:0] o0_dat, o1_dat;
  logic       o0_req, o1_req, o0_ack, o1_ack;
  logic [15:0] o_cnt_0, o_cnt_1;

  logic [5:0] r_i0_src = 0, r_i0_dst = 0;
  logic [3:0] r_i0_dat = 0;
  logic       r_i0_req = 0, r_i0_ack;
  logic [5:0] r_o0_src, r_o0_dst, r_o1_src, r_o1_dst;
  logic [3:0] r_o0_dat, r_o1_dat;
  logic       r_o0_req, r_o1_req, r_o0_ack, r_o1_ack;
  logic [15:0] r_cnt_0, r_cnt_1;

  logic hold0 = 0, hold1 = 0;
  int   n0 = 0, n1 = 0, rn0 = 0, rn1 = 0;
  logic [3:0] log0[$], log1[$];
  logic [5:0] last1_dst, rlast_dst;
  int   tests = 0, fails = 0;

  always #5 i_clk = ~i_clk;

  nd_1to2 dut (
    .i_clk(i_clk), .reset(reset),
    .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_req(i0_req), .i0_ack(i0_ack),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_req(o0_req), .o0_ack(o0_ack),
    .o1_src(o1_src), .o1_dst(o1_dst), .o1_dat(o1_dat), .o1_req(o1_req), .o1_ack(o1_ack),
    .o_cnt_0(o_cnt_0), .o_cnt_1(o_cnt_1)
  );

  nd_1to2 #(.OPER_1(NS_GT_OP), .REF_VAL_1(2), .IS_RANGE(NS_TRUE),
            .OPER_2(NS_LT_OP), .REF_VAL_2(5)) dut_r (
    .i_clk(i_clk), .reset(reset),
    .i0_src(r_i0_src), .i0_dst(r_i0_dst), .i0_dat(r_i0_dat), .i0_req(r_i0_req), .i0_ack(r_i0_ack),
    .o0_src(r_o0_src), .o0_dst(r_o0_dst), .o0_dat(r_o0_dat), .o0_req(r_o0_req), .o0_ack(r_o0_ack),
    .o1_src(r_o1_src), .o1_dst(r_o1_dst), .o1_dat(r_o1_dat), .o1_req(r_o1_req), .o1_ack(r_o1_ack),
    .o_cnt_0(r_cnt_0), .o_cnt_1(r_cnt_1)
  );

  // Sink models: ack a presented request (unless held), log the delivery, drop ack after req falls.
  always @(posedge i_clk or posedge reset)
    if (reset) o0_ack <= 0;
    else if (o0_req && !o0_ack && !hold0) begin o0_ack <= 1; n0 <= n0 + 1; log0.push_back(o0_dat); end
    else if (!o0_req) o0_ack <= 0;

  always @(posedge i_clk or posedge reset)
    if (reset) o1_ack <= 0;
    else if (o1_req && !o1_ack && !hold1) begin
      o1_ack <= 1; n1 <= n1 + 1; log1.push_back(o1_dat); last1_dst <= o1_dst;
    end else if (!o1_req) o1_ack <= 0;

  always @(posedge i_clk or posedge reset)
    if (reset) r_o0_ack <= 0;
    else if (r_o0_req && !r_o0_ack) begin r_o0_ack <= 1; rn0 <= rn0 + 1; rlast_dst <= r_o0_dst; end
    else if (!r_o0_req) r_o0_ack <= 0;

  always @(posedge i_clk or posedge reset)
    if (reset) r_o1_ack <= 0;
    else if (r_o1_req && !r_o1_ack) begin r_o1_ack <= 1; rn1 <= rn1 + 1; rlast_dst <= r_o1_dst; end
    else if (!r_o1_req) r_o1_ack <= 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send(input logic [5:0] d, input logic [3:0] v);
    int n;
    @(negedge i_clk);
    i0_src = 6'h2a; i0_dst = d; i0_dat = v; i0_req = 1;
    n = 0;
    while (!i0_ack && n < 60) begin @(negedge i_clk); n++; end
    chk("send_ack", i0_ack, 1);
    i0_req = 0;
    n = 0;
    while (i0_ack && n < 60) begin @(negedge i_clk); n++; end
    chk("send_ack_low", i0_ack, 0);
  endtask

  task automatic send_r(input logic [5:0] d);
    int n;
    @(negedge i_clk);
    r_i0_src = 6'h11; r_i0_dst = d; r_i0_dat = d[3:0]; r_i0_req = 1;
    n = 0;
    while (!r_i0_ack && n < 60) begin @(negedge i_clk); n++; end
    chk("send_r_ack", r_i0_ack, 1);
    r_i0_req = 0;
    n = 0;
    while (r_i0_ack && n < 60) begin @(negedge i_clk); n++; end
  endtask

  initial begin
    int b0, b1, k0, k1, p0, p1, n;

    // Reset state
    #12;
    chk("rst_i0_ack", i0_ack, 0);
    chk("rst_o0_req", o0_req, 0);
    chk("rst_o1_req", o1_req, 0);
    chk("rst_o0_dst", o0_dst, 0);
    chk("rst_cnt0", o_cnt_0, 0);
    @(negedge i_clk); reset = 0;
    wait_cyc(2);

    // Latency and routing of dst=1 to output 0
    hold0 = 1;
    @(negedge i_clk);
    i0_src = 6'h07; i0_dst = 1; i0_dat = 5; i0_req = 1;
    @(posedge i_clk); #1;
    chk("lat_ack_e0", i0_ack, 1);
    chk("lat_o0req_e0", o0_req, 0);
    @(posedge i_clk); #1;
    chk("lat_o0req_e1", o0_req, 1);
    chk("t1_o0_dst", o0_dst, 1);
    chk("t1_o0_dat", o0_dat, 5);
    chk("t1_o0_src", o0_src, 7);
    chk("t1_o1_req", o1_req, 0);
    @(negedge i_clk); i0_req = 0; hold0 = 0;
    wait_cyc(6);
    chk("t1_n0", n0, 1);
    chk("t1_n1", n1, 0);

    // dst=0 goes to output 1
    send(0, 3);
    wait_cyc(6);
    chk("t2_n1", n1, 1);
    chk("t2_o1_dst", last1_dst, 0);
    chk("t2_o1_dat", log1[0], 3);
    chk("t2_cnt1", o_cnt_1, STATS);
    chk("t2_cnt0", o_cnt_0, STATS);

    // Backpressure on output 0 with QDEPTH=2
    hold0 = 1;
    send(2, 1);
    send(2, 2);
    @(negedge i_clk);
    i0_dst = 2; i0_dat = 3; i0_req = 1;
    wait_cyc(5);
    chk("t3_full_noack", i0_ack, 0);
    chk("t3_o0_req_held", o0_req, 1);
    chk("t3_o0_head", o0_dat, 1);
    hold0 = 0;
    n = 0;
    while (!i0_ack && n < 60) begin @(negedge i_clk); n++; end
    chk("t3_third_ack", i0_ack, 1);
    i0_req = 0;
    wait_cyc(2);
    send(0, 9);
    wait_cyc(12);
    chk("t3_n0", n0, 4);
    chk("t3_n1", n1, 2);
    chk("t3_o1_dat", log1[1], 9);
    chk("t3_ord1", log0[1], 1);
    chk("t3_ord2", log0[2], 2);
    chk("t3_ord3", log0[3], 3);

    // Range node sweep: 2 < dst < 5 goes to output 0
    for (int d = 0; d < 8; d++) begin
      p0 = rn0; p1 = rn1;
      send_r(6'(d));
      wait_cyc(6);
      chk($sformatf("range_o0_d%0d", d), rn0 - p0, (d == 3 || d == 4) ? 1 : 0);
      chk($sformatf("range_o1_d%0d", d), rn1 - p1, (d == 3 || d == 4) ? 0 : 1);
      chk($sformatf("range_dst_d%0d", d), rlast_dst, d);
    end

    // Streaming: per-output FIFO order
    b0 = log0.size(); b1 = log1.size();
    for (int i = 0; i < 8; i++) send(6'(i % 4), 4'(i));
    wait_cyc(12);
    chk("strm_n0", log0.size() - b0, 6);
    chk("strm_n1", log1.size() - b1, 2);
    k0 = 0; k1 = 0;
    for (int i = 0; i < 8; i++)
      if (i % 4 != 0) begin chk("strm_o0", log0[b0 + k0], i); k0++; end
      else            begin chk("strm_o1", log1[b1 + k1], i); k1++; end

    // Reset mid-handshake with a message queued behind it
    hold1 = 1;
    send(0, 4);
    send(0, 6);
    wait_cyc(3);
    chk("t5_o1_req_pre", o1_req, 1);
    p1 = n1;
    @(negedge i_clk); reset = 1; #1;
    chk("t5_rst_o1_req", o1_req, 0);
    chk("t5_rst_i0_ack", i0_ack, 0);
    chk("t5_rst_o1_dat", o1_dat, 0);
    chk("t5_rst_cnt1", o_cnt_1, 0);
    @(negedge i_clk); reset = 0; hold1 = 0;
    wait_cyc(4);
    chk("t5_no_stale", n1 - p1, 0);
    send(0, 11);
    wait_cyc(8);
    chk("t5_n1", n1 - p1, 1);
    chk("t5_dat", log1[log1.size() - 1], 11);
    chk("t5_cnt1", o_cnt_1, STATS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
